// File: rtl/rgb_source_pkg.sv
// Shared types and constants for the RGB test-pattern source.
package rgb_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_SYNC,
    ST_V_BACK,
    ST_V_ACTIVE,
    ST_V_FRONT
  } frame_state_e;

  typedef enum logic [1:0] {
    PAT_COUNTER,
    PAT_SOLID,
    PAT_GRADIENT,
    PAT_CHECKER
  } pattern_e;

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_BACK,
    PH_ACTIVE,
    PH_FRONT
  } phase_e;

  localparam logic [7:0] FILL_MID  = 8'hBB;
  localparam logic [7:0] FILL_LAST = 8'hCC;
  localparam logic [7:0] FILL_ON   = 8'hFF;

  // Which part of a sync/back/active/front period a position falls in.
  function automatic phase_e axis_phase(input logic [15:0] pos,
                                        input logic [15:0] sync_len,
                                        input logic [15:0] back_len,
                                        input logic [15:0] act_len);
    if (pos < sync_len)                            return PH_SYNC;
    else if (pos < sync_len + back_len)            return PH_BACK;
    else if (pos < sync_len + back_len + act_len)  return PH_ACTIVE;
    else                                           return PH_FRONT;
  endfunction

  function automatic frame_state_e phase_to_state(input phase_e ph);
    case (ph)
      PH_SYNC:   return ST_V_SYNC;
      PH_BACK:   return ST_V_BACK;
      PH_ACTIVE: return ST_V_ACTIVE;
      default:   return ST_V_FRONT;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pattern_source_if.sv
// Video output bundle: de/hs/vs/color plus frame_start and busy status.
interface rgb_pattern_source_if #(
  parameter int CHANNEL_COUNT = 3
);
  logic                            rgb_de;
  logic                            rgb_hs;
  logic                            rgb_vs;
  logic [0:CHANNEL_COUNT-1][7:0]   rgb_color;
  logic                            frame_start;
  logic                            busy;

  modport master (output rgb_de, rgb_hs, rgb_vs, rgb_color, frame_start, busy);
  modport slave  (input  rgb_de, rgb_hs, rgb_vs, rgb_color, frame_start, busy);
endinterface

// File: rtl/rgb_axis_counter.sv
// Position counter over one sync/back/active/front period with phase
// decode and a wrap pulse on the last position of the period.
module rgb_axis_counter
  import rgb_source_pkg::*;
#(
  parameter int CW    = 9,
  parameter int SYNC  = 1,
  parameter int BACK  = 0,
  parameter int FRONT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [CW-1:0] act_len,
  output logic [CW-1:0] pos,
  output phase_e        phase,
  output logic          wrap
);

  localparam logic [CW-1:0] FIXED_LEN = CW'(SYNC + BACK + FRONT);

  logic [CW-1:0] last_pos;

  assign last_pos = FIXED_LEN + act_len - CW'(1);
  assign wrap     = advance && (pos == last_pos);
  assign phase    = axis_phase(16'(pos), 16'(SYNC), 16'(BACK), 16'(act_len));

  // Position register: held at 0 while cleared, wraps at end of period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pos <= '0;
    else if (clear)    pos <= '0;
    else if (advance)  pos <= wrap ? '0 : pos + CW'(1);
  end

endmodule

// File: rtl/rgb_pattern_source.sv
// RGB test-pattern video source: frame timing plus four fill patterns.
// Optional RGB_SOURCE_FRAME_TAG_EN: counter pattern puts a frame number on
// the last channel instead of the constant fill.
//
// state       | meaning
// ST_IDLE     | no frame; outputs idle, waiting for I_enable
// ST_V_SYNC   | vertical sync lines (vs low)
// ST_V_BACK   | vertical back-porch lines
// ST_V_ACTIVE | lines carrying active pixels
// ST_V_FRONT  | vertical front-porch lines; frame boundary at the end
module rgb_pattern_source
  import rgb_source_pkg::*;
#(
  parameter int MAX_WIDTH     = 64,
  parameter int MAX_HEIGHT    = 64,
  parameter int CHANNEL_COUNT = 3,
  parameter int H_SYNC        = 1,
  parameter int H_BACK        = 0,
  parameter int H_FRONT       = 2,
  parameter int V_SYNC        = 1,
  parameter int V_BACK        = 1,
  parameter int V_FRONT       = 1
) (
  input  logic                            I_rgb_clk,
  input  logic                            I_rst_n,
  input  logic                            I_enable,
  input  logic [$clog2(MAX_WIDTH)-1:0]    I_image_width,
  input  logic [$clog2(MAX_HEIGHT)-1:0]   I_image_height,
  input  logic [1:0]                      I_pattern_sel,
  rgb_pattern_source_if.master            vid
);

  // Extra bits so line/frame totals never overflow.
  localparam int CW = $clog2(MAX_WIDTH) + 3;
  localparam int VW = $clog2(MAX_HEIGHT) + 3;

  typedef logic [0:CHANNEL_COUNT-1][7:0] pix_t;

  frame_state_e  state, next_state;
  logic          frame_go;
  logic [CW-1:0] w_lat;
  logic [VW-1:0] h_lat;
  pattern_e      pat_lat;

  logic [CW-1:0] h_pos;
  phase_e        h_phase;
  logic          h_wrap;
  logic [VW-1:0] v_pos;
  phase_e        v_phase;
  logic          v_wrap;
  phase_e        v_next_phase;

  logic          running;
  logic          frame_first;
  logic          de_int;
  logic [7:0]    x8;
  logic          y0;
  logic [7:0]    p_reg, p_cur, p_pix;
  logic [7:0]    tag_byte;
  pix_t          pix;

  assign running = (state != ST_IDLE);

  rgb_axis_counter #(.CW(CW), .SYNC(H_SYNC), .BACK(H_BACK), .FRONT(H_FRONT)) u_h_cnt (
    .clk     (I_rgb_clk),
    .rst_n   (I_rst_n),
    .clear   (!running),
    .advance (running),
    .act_len (w_lat),
    .pos     (h_pos),
    .phase   (h_phase),
    .wrap    (h_wrap)
  );

  rgb_axis_counter #(.CW(VW), .SYNC(V_SYNC), .BACK(V_BACK), .FRONT(V_FRONT)) u_v_cnt (
    .clk     (I_rgb_clk),
    .rst_n   (I_rst_n),
    .clear   (!running),
    .advance (h_wrap),
    .act_len (h_lat),
    .pos     (v_pos),
    .phase   (v_phase),
    .wrap    (v_wrap)
  );

  assign v_next_phase = axis_phase(16'(v_pos) + 16'd1, 16'(V_SYNC), 16'(V_BACK), 16'(h_lat));

  // Frame state register.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next state: vertical moves only at end of line; enable checked only at frame boundaries.
  always_comb begin
    next_state = state;
    frame_go   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (I_enable) begin
          next_state = ST_V_SYNC;
          frame_go   = 1'b1;
        end
      end
      default: begin
        if (h_wrap) begin
          if (v_wrap) begin
            if (I_enable) begin
              next_state = ST_V_SYNC;
              frame_go   = 1'b1;
            end else begin
              next_state = ST_IDLE;
            end
          end else begin
            next_state = phase_to_state(v_next_phase);
          end
        end
      end
    endcase
  end

  // Frame parameters are captured once per frame; zero sizes become 1.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      w_lat   <= CW'(1);
      h_lat   <= VW'(1);
      pat_lat <= PAT_COUNTER;
    end else if (frame_go) begin
      w_lat   <= (I_image_width  == '0) ? CW'(1) : CW'(I_image_width);
      h_lat   <= (I_image_height == '0) ? VW'(1) : VW'(I_image_height);
      pat_lat <= pattern_e'(I_pattern_sel);
    end
  end

`ifdef RGB_SOURCE_FRAME_TAG_EN
  logic [7:0] frame_num;
  logic       tag_armed;

  // Frame number: 0 for the first frame after reset, +1 on each later start.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      frame_num <= '0;
      tag_armed <= 1'b0;
    end else if (frame_go) begin
      if (tag_armed) frame_num <= frame_num + 8'd1;
      tag_armed <= 1'b1;
    end
  end

  assign tag_byte = frame_num;
`else
  assign tag_byte = FILL_LAST;
`endif

  assign frame_first = running && (h_pos == '0) && (v_pos == '0);
  assign de_int      = (state == ST_V_ACTIVE) && (h_phase == PH_ACTIVE);
  assign x8          = 8'(h_pos - CW'(H_SYNC + H_BACK));
  assign y0          = 1'(v_pos - VW'(V_SYNC + V_BACK));
  assign p_cur       = frame_first ? 8'd0 : p_reg;
  assign p_pix       = p_cur + 8'd1;

  // Pixel value for the current position in the latched pattern.
  always_comb begin
    pix = '0;
    unique case (pat_lat)
      PAT_COUNTER: begin
        for (int c = 0; c < CHANNEL_COUNT; c++) pix[c] = FILL_MID;
        pix[CHANNEL_COUNT-1] = tag_byte;
        pix[0]               = p_pix;
      end
      PAT_SOLID:    pix = {CHANNEL_COUNT{FILL_ON}};
      PAT_GRADIENT: pix = {CHANNEL_COUNT{x8}};
      PAT_CHECKER:  pix = (x8[0] ^ y0) ? {CHANNEL_COUNT{FILL_ON}} : '0;
    endcase
  end

  // Registered outputs, one clock behind the counters.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vid.rgb_de      <= 1'b0;
      vid.rgb_hs      <= 1'b1;
      vid.rgb_vs      <= 1'b1;
      vid.rgb_color   <= '0;
      vid.frame_start <= 1'b0;
      vid.busy        <= 1'b0;
      p_reg           <= '0;
    end else begin
      vid.rgb_de      <= de_int;
      vid.rgb_hs      <= !(running && (h_phase == PH_SYNC));
      vid.rgb_vs      <= !(running && (v_phase == PH_SYNC));
      vid.rgb_color   <= de_int ? pix : '0;
      vid.frame_start <= frame_first;
      vid.busy        <= running;
      p_reg           <= de_int ? p_pix : p_cur;
    end
  end

endmodule

// File: doc/rgb_pattern_source.md
# rgb_pattern_source

Synthesizable RGB video source that drives the same de/hs/vs/color interface that `Input_Logic` consumes. It generates complete frames with programmable active size and fixed porches, and fills the active pixels with one of four test patterns. It sits in front of `Input_Logic` as an on-FPGA stimulus and self-test path that bypasses the HDMI receiver, selected by a mux at the top level.

## Interface
- MAX_WIDTH, 64: upper bound of the active width; width ports are $clog2(MAX_WIDTH) bits.
- MAX_HEIGHT, 64: upper bound of the active height; height ports are $clog2(MAX_HEIGHT) bits.
- CHANNEL_COUNT, 3: number of 8-bit color channels.
- H_SYNC, 1 / H_BACK, 0 / H_FRONT, 2: horizontal sync, back porch and front porch, in clocks.
- V_SYNC, 1 / V_BACK, 1 / V_FRONT, 1: vertical sync, back porch and front porch, in whole lines.

Ports:
- I_rgb_clk, in, 1: pixel clock.
- I_rst_n, in, 1: reset, asynchronous, active-low.
- I_enable, in, 1: run request; sampled only at frame boundaries.
- I_image_width, in, $clog2(MAX_WIDTH): active pixels per line; latched at frame start.
- I_image_height, in, $clog2(MAX_HEIGHT): active lines per frame; latched at frame start.
- I_pattern_sel, in, 2: 0 = counter, 1 = solid, 2 = horizontal gradient, 3 = checkerboard; latched at frame start.
- O_rgb_de, out, 1: data enable.
- O_rgb_hs, out, 1: horizontal sync, active-low.
- O_rgb_vs, out, 1: vertical sync, active-low.
- O_rgb_color, out, 8 × [0:CHANNEL_COUNT-1]: pixel data.
- O_frame_start, out, 1: one-cycle pulse on the first clock of each frame.
- O_busy, out, 1: high while a frame is in progress.

## Operation
**Frame FSM states:** IDLE → V_SYNC → V_BACK → V_ACTIVE → V_FRONT → (V_SYNC if I_enable, else IDLE).
- The FSM advances between vertical states only at the end of a line.
- Reset drives every output to its idle value: de=0, hs=1, vs=1, color=0, frame_start=0, busy=0.

**Line structure:**
- Every line in every non-IDLE state has H_SYNC + H_BACK + W + H_FRONT clocks.
- W and H are the latched width and height. A latched value of 0 is treated as 1.
- hs=0 for the first H_SYNC clocks of each line.
- vs=0 for all clocks of the V_SYNC lines.
- de=1 only during V_ACTIVE lines, in the W clocks that follow the sync and back porch.

**Patterns** (x = column, y = row, p = running active-pixel index within the frame, starting at 1, 8-bit wrap):
- Counter: ch0 = p; ch1..ch(N-2) = 8'hBB; ch(N-1) = 8'hCC.
- Solid: all channels 8'hFF.
- Gradient: all channels = x[7:0].
- Checkerboard: all channels = 8'hFF if x[0]^y[0], else 8'h00.
- Color is 0 whenever de=0.

**Arithmetic:**
- x and y counters are sized to the width/height ports.
- p is an 8-bit register and wraps 255 → 0.
- The line and frame totals are computed in width+3 bits so they cannot overflow.

**Boundary conditions:**
- I_enable falls mid-frame: the current frame completes, then the FSM goes to IDLE.
- I_enable rises in IDLE: the frame starts on the next clock.
- Width, height or pattern changes mid-frame are ignored until the next frame start.
- Reset mid-frame: outputs return to idle values immediately (asynchronous). After release the FSM restarts at IDLE.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE with I_enable=1 sampled at edge k: at edge k+1 outputs show vs=0, hs=0, frame_start=1, busy=1.
- First de=1 occurs at clock (V_SYNC + V_BACK) × L + H_SYNC + H_BACK after frame start, where L is the line length.
- Frame length is (V_SYNC + V_BACK + H + V_FRONT) × L clocks.
- Back-to-back frames have no gap clocks.
- busy falls on the clock after the last V_FRONT clock when the FSM returns to IDLE.

## Configuration
- RGB_SOURCE_FRAME_TAG_EN defined: in counter pattern, ch(N-1) carries an 8-bit frame number.
  - The frame number is 0 after reset and increments at each frame_start after the first.
- Undefined: ch(N-1) is the constant 8'hCC, and no frame register is synthesized.

## Structure
- `rgb_source_pkg` contains:
  - the frame FSM state enum;
  - the pattern enum (PAT_COUNTER, PAT_SOLID, PAT_GRADIENT, PAT_CHECKER);
  - the idle/fill constants 8'hBB, 8'hCC and 8'hFF.
- Sub-module `rgb_axis_counter`: a position counter with phase flags (sync, back, active, front) and an end-of-period wrap pulse.
  - Instantiated once for horizontal, counting clocks.
  - Instantiated once for vertical, counting lines and advanced by the horizontal wrap.

## Test plan
- **Default timing, 16×8 frame, counter pattern:**
  - Stimulus: reset, then enable=1, width=16, height=8.
  - Response: line length 19 clocks, frame length 209 clocks; each active line has hs low 1 clock, then 16 de-high clocks, then 2 idle clocks.
  - Across the frame, ch0 runs 1..128, ch1 = 8'hBB, ch2 = 8'hCC.
- **Back-to-back frames:** run 4 frames; frame_start is 209 clocks apart and p restarts at 1 each frame.
  - With RGB_SOURCE_FRAME_TAG_EN, ch2 = 0, 1, 2, 3 in successive frames.
- **Enable drop:** deassert enable at active pixel 40 of frame 1; frame 1 completes all 128 de cycles, then busy=0 and outputs hold idle values.
- **Mid-frame size change and zero size:**
  - width changes 16 → 4 during V_ACTIVE: the current frame keeps 16 pixels per line and the next frame uses 4.
  - width=0: each line has exactly 1 de cycle.
- **Reset mid-frame:** assert I_rst_n low during de; in the same cycle de=0, hs=1, vs=1, color=0. After release with enable=1, the next frame starts cleanly with frame_start.
- **Loopback into Input_Logic:** a 16×8 frame from this block drives Input_Logic, which reports O_image_width=16, O_image_height=8 and O_image_valid=1 after the second frame.
